// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// edsac_sram_pkg : SRAM bus widths, grant bit positions and arbiter FSM states.
// Rev 1.0
// ----------------------------------------------------------------------------
package edsac_sram_pkg;

  localparam int SRAM_ADDR_W = 19;
  localparam int SRAM_DATA_W = 16;

  // Bit positions inside the one-hot grant vector
  localparam int GNT_A = 0;
  localparam int GNT_B = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RECOVER = 2'd3
  } sram_state_e;

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_arbiter_if : client ports A/B plus the asynchronous SRAM pin bundle.
// Rev 1.0
// ----------------------------------------------------------------------------
interface sram_arbiter_if;
  import edsac_sram_pkg::*;

  logic                   a_req;
  logic                   a_we;
  logic [SRAM_ADDR_W-1:0] a_addr;
  logic [SRAM_DATA_W-1:0] a_wdata;
  logic [SRAM_DATA_W-1:0] a_rdata;
  logic                   a_ack;

  logic                   b_req;
  logic                   b_we;
  logic [SRAM_ADDR_W-1:0] b_addr;
  logic [SRAM_DATA_W-1:0] b_wdata;
  logic [SRAM_DATA_W-1:0] b_rdata;
  logic                   b_ack;

  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [SRAM_DATA_W-1:0] sram_dq_o;
  logic [SRAM_DATA_W-1:0] sram_dq_i;
  logic                   sram_dq_oe;
  logic                   sram_cs_n;
  logic                   sram_oe_n;
  logic                   sram_we_n;
  logic                   busy;

  // Arbiter side
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  sram_dq_i,
    output a_rdata, a_ack, b_rdata, b_ack,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_cs_n, sram_oe_n, sram_we_n,
    output busy
  );

  // Client / SRAM side
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output sram_dq_i,
    input  a_rdata, a_ack, b_rdata, b_ack,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_cs_n, sram_oe_n, sram_we_n,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/sram_arb_grant.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_arb_grant : two-requester one-hot grant; fixed A-over-B priority, or
// round-robin with a last-grant pointer when SRAM_ARB_RR_EN is defined.
// Rev 1.0
// ----------------------------------------------------------------------------
module sram_arb_grant
  import edsac_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       take,
  output logic [1:0] grant
);

`ifdef SRAM_ARB_RR_EN
  logic last_b_q;
  logic last_b_d;

  always_comb begin
    grant = 2'b00;
    if (req_a && req_b) begin
      grant[GNT_A] = last_b_q;
      grant[GNT_B] = ~last_b_q;
    end else if (req_a) begin
      grant[GNT_A] = 1'b1;
    end else if (req_b) begin
      grant[GNT_B] = 1'b1;
    end
    last_b_d = last_b_q;
    if (take) begin
      last_b_d = grant[GNT_B];
    end
  end

  // Reset to "B last" so the first contested grant goes to A
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, take};

  always_comb begin
    grant = 2'b00;
    if (req_a) begin
      grant[GNT_A] = 1'b1;
    end else if (req_b) begin
      grant[GNT_B] = 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_arbiter : two-port arbiter for an asynchronous SRAM, IDLE/SETUP/STROBE/
// RECOVER sequencing with registered pins. Macro SRAM_ARB_RR_EN = round-robin.
// Rev 1.0
// ----------------------------------------------------------------------------
module sram_arbiter
  import edsac_sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_arbiter_if.slave  bus
);

  localparam logic [3:0] c_strobe_load = 4'(WAIT_CYCLES - 1);

  sram_state_e            state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic                   win_b_q, win_b_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] dq_o_q, dq_o_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   cs_n_q, cs_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic                   a_ack_q, a_ack_d;
  logic                   b_ack_q, b_ack_d;
  logic [SRAM_DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [SRAM_DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic                   busy_q, busy_d;

  logic [1:0]             w_grant;
  logic                   w_take;
  logic                   w_sel_b;

  assign w_take  = (state_q == ST_IDLE) && (bus.a_req || bus.b_req);
  assign w_sel_b = w_grant[GNT_B];

  sram_arb_grant u_grant (
    .clk   (clk),
    .rst_n (rst_n),
    .req_a (bus.a_req),
    .req_b (bus.b_req),
    .take  (w_take),
    .grant (w_grant)
  );

  // Outputs are computed for the state being entered, so every pin is a flop
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    win_b_d   = win_b_q;
    addr_d    = addr_q;
    dq_o_d    = dq_o_q;
    dq_oe_d   = dq_oe_q;
    cs_n_d    = cs_n_q;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (w_take) begin
          state_d = ST_SETUP;
          win_b_d = w_sel_b;
          we_d    = w_sel_b ? bus.b_we    : bus.a_we;
          addr_d  = w_sel_b ? bus.b_addr  : bus.a_addr;
          dq_o_d  = w_sel_b ? bus.b_wdata : bus.a_wdata;
          dq_oe_d = w_sel_b ? bus.b_we    : bus.a_we;
          cs_n_d  = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = c_strobe_load;
        we_n_d  = ~we_q;
        oe_n_d  = we_q;
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RECOVER;
          a_ack_d = ~win_b_q;
          b_ack_d = win_b_q;
          if (!we_q) begin
            if (win_b_q) begin
              b_rdata_d = bus.sram_dq_i;
            end else begin
              a_rdata_d = bus.sram_dq_i;
            end
          end
        end else begin
          cnt_d  = cnt_q - 4'd1;
          we_n_d = ~we_q;
          oe_n_d = we_q;
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      win_b_q   <= 1'b0;
      addr_q    <= '0;
      dq_o_q    <= '0;
      dq_oe_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      win_b_q   <= win_b_d;
      addr_q    <= addr_d;
      dq_o_q    <= dq_o_d;
      dq_oe_q   <= dq_oe_d;
      cs_n_q    <= cs_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.sram_addr  = addr_q;
  assign bus.sram_dq_o  = dq_o_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.sram_cs_n  = cs_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.a_ack      = a_ack_q;
  assign bus.b_ack      = b_ack_q;
  assign bus.a_rdata    = a_rdata_q;
  assign bus.b_rdata    = b_rdata_q;
  assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sram_arbiter : directed bench for sram_arbiter (WAIT_CYCLES 2, 1 and 15),
// expectations follow SRAM_ARB_RR_EN when the macro is defined.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sram_arbiter;
  import edsac_sram_pkg::*;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  int         n_a, n_b, oe1, oe15, at1, at15, ack_seen;
  logic [3:0] order;

  always #5 clk = ~clk;

  sram_arbiter_if bus ();
  sram_arbiter_if bus1 ();
  sram_arbiter_if bus15 ();

  sram_arbiter #(.WAIT_CYCLES(2))  u_dut     (.clk(clk), .rst_n(rst_n), .bus(bus));
  sram_arbiter #(.WAIT_CYCLES(1))  u_dut_w1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  sram_arbiter #(.WAIT_CYCLES(15)) u_dut_w15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

  // SRAM model: 256 words aliased on the low address byte, preset to A5xx
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA500 | 16'(i);
    end else if (!bus.sram_cs_n && !bus.sram_we_n) begin
      mem[bus.sram_addr[7:0]] <= bus.sram_dq_o;
    end
  end
  assign bus.sram_dq_i   = (!bus.sram_cs_n && !bus.sram_oe_n) ? mem[bus.sram_addr[7:0]] : 16'h0000;
  assign bus1.sram_dq_i  = (!bus1.sram_cs_n && !bus1.sram_oe_n) ? 16'h1111 : 16'h0000;
  assign bus15.sram_dq_i = (!bus15.sram_cs_n && !bus15.sram_oe_n) ? 16'h2222 : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic proto_ok(input logic cs_n, input logic oe_n,
                                    input logic we_n, input logic dq_oe);
    return !((!oe_n && !we_n) || (cs_n && (!oe_n || !we_n)) || (!oe_n && dq_oe));
  endfunction

  always @(negedge clk) begin
    chk("proto_w2", 32'(proto_ok(bus.sram_cs_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe)), 32'd1);
    chk("proto_w1", 32'(proto_ok(bus1.sram_cs_n, bus1.sram_oe_n, bus1.sram_we_n, bus1.sram_dq_oe)), 32'd1);
    chk("proto_w15", 32'(proto_ok(bus15.sram_cs_n, bus15.sram_oe_n, bus15.sram_we_n, bus15.sram_dq_oe)), 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle that samples the request: ack due 4 cycles later
  task automatic wait_ack(input string tag, input bit exp_a, input bit exp_b);
    tick();
    tick();
    tick();
    chk({tag, "_early"}, 32'({bus.a_ack, bus.b_ack}), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'({bus.a_ack, bus.b_ack}), 32'({exp_a, exp_b}));
  endtask

  task automatic pair(input string tag, input logic [18:0] addr_a, input logic [18:0] addr_b);
    bit first_b;
    first_b    = RR;
    bus.a_we   = 1'b0;
    bus.b_we   = 1'b0;
    bus.a_addr = addr_a;
    bus.b_addr = addr_b;
    bus.a_req  = 1'b1;
    bus.b_req  = 1'b1;
    wait_ack({tag, "_first"}, !first_b, first_b);
    if (first_b) bus.b_req = 1'b0;
    else         bus.a_req = 1'b0;
    tick();
    wait_ack({tag, "_second"}, first_b, !first_b);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    chk({tag, "_a_rdata"}, 32'(bus.a_rdata), 32'(16'hA500 | 16'(addr_a[7:0])));
    chk({tag, "_b_rdata"}, 32'(bus.b_rdata), 32'(16'hA500 | 16'(addr_b[7:0])));
    tick();
  endtask

  initial begin
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = '0; bus1.a_wdata = '0;
    bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = '0; bus1.b_wdata = '0;
    bus15.a_req = 0; bus15.a_we = 0; bus15.a_addr = '0; bus15.a_wdata = '0;
    bus15.b_req = 0; bus15.b_we = 0; bus15.b_addr = '0; bus15.b_wdata = '0;

    // Reset state
    tick();
    tick();
    chk("rst_strobes", 32'({bus.sram_cs_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}), 32'h0000_000E);
    chk("rst_addr_dq", 32'({bus.sram_addr, bus.sram_dq_o}), 32'd0);
    chk("rst_busy_ack", 32'({bus.busy, bus.a_ack, bus.b_ack}), 32'd0);
    chk("rst_rdata", {bus.a_rdata, bus.b_rdata}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Write 0xBEEF to 0x12345 from port A
    bus.a_we    = 1'b1;
    bus.a_addr  = 19'h12345;
    bus.a_wdata = 16'hBEEF;
    bus.a_req   = 1'b1;
    tick();
    chk("wr_setup_pins", 32'({bus.sram_cs_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe, bus.busy}), 32'h0000_000F);
    chk("wr_setup_addr", 32'(bus.sram_addr), 32'h0001_2345);
    chk("wr_setup_dq", 32'(bus.sram_dq_o), 32'h0000_BEEF);
    bus.a_addr  = 19'h00001;
    bus.a_wdata = 16'h0000;
    bus.a_we    = 1'b0;
    tick();
    chk("wr_strobe_pins", 32'({bus.sram_cs_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}), 32'h0000_0005);
    chk("wr_strobe_addr", 32'(bus.sram_addr), 32'h0001_2345);
    tick();
    chk("wr_early", 32'({bus.a_ack, bus.b_ack}), 32'd0);
    tick();
    chk("wr_ack", 32'({bus.a_ack, bus.b_ack}), 32'h0000_0002);
    chk("wr_recover_pins", 32'({bus.sram_cs_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}), 32'h0000_0007);
    chk("wr_recover_dq", 32'(bus.sram_dq_o), 32'h0000_BEEF);
    bus.a_req = 1'b0;
    tick();
    chk("wr_idle", 32'({bus.sram_cs_n, bus.sram_dq_oe, bus.busy, bus.a_ack}), 32'h0000_0008);
    chk("wr_mem", 32'(mem[8'h45]), 32'h0000_BEEF);

    // Read it back
    bus.a_we   = 1'b0;
    bus.a_addr = 19'h12345;
    bus.a_req  = 1'b1;
    wait_ack("rd", 1'b1, 1'b0);
    chk("rd_rdata", 32'(bus.a_rdata), 32'h0000_BEEF);
    bus.a_req = 1'b0;
    tick();

    // Two simultaneous pairs
    pair("pair1", 19'h00010, 19'h00020);
    pair("pair2", 19'h00030, 19'h00040);

    // Both requests held for 20 cycles
    bus.a_addr = 19'h00011;
    bus.b_addr = 19'h00021;
    bus.a_req  = 1'b1;
    bus.b_req  = 1'b1;
    n_a   = 0;
    n_b   = 0;
    order = 4'b0000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.a_ack) n_a++;
      if (bus.b_ack) n_b++;
      if (bus.a_ack || bus.b_ack) order = {order[2:0], bus.b_ack};
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    chk("hold_a_acks", 32'(n_a), RR ? 32'd2 : 32'd4);
    chk("hold_b_acks", 32'(n_b), RR ? 32'd2 : 32'd0);
    chk("hold_order", 32'(order), RR ? 32'h0000_000A : 32'd0);
    tick();
    chk("hold_idle", 32'(bus.busy), 32'd0);

    // Reset in the second STROBE cycle of a write
    bus.a_we    = 1'b1;
    bus.a_addr  = 19'h00077;
    bus.a_wdata = 16'h5A5A;
    bus.a_req   = 1'b1;
    tick();
    tick();
    tick();
    chk("rstmid_strobe", 32'(bus.sram_we_n), 32'd0);
    rst_n     = 1'b0;
    bus.a_req = 1'b0;
    tick();
    chk("rstmid_pins", 32'({bus.sram_we_n, bus.sram_cs_n, bus.sram_dq_oe, bus.busy}), 32'h0000_000C);
    chk("rstmid_rdata", {bus.a_rdata, bus.b_rdata}, 32'd0);
    rst_n    = 1'b1;
    ack_seen = (bus.a_ack || bus.b_ack) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.a_ack || bus.b_ack) ack_seen++;
    end
    chk("rstmid_no_ack", 32'(ack_seen), 32'd0);

    // Read strobe width at WAIT_CYCLES = 1 and 15
    bus1.a_addr  = 19'h00003;
    bus1.a_req   = 1'b1;
    bus15.a_addr = 19'h00003;
    bus15.a_req  = 1'b1;
    oe1  = 0;
    oe15 = 0;
    at1  = 0;
    at15 = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (!bus1.sram_oe_n) oe1++;
      if (!bus15.sram_oe_n) oe15++;
      if (bus1.a_ack) begin
        at1 = i;
        bus1.a_req = 1'b0;
      end
      if (bus15.a_ack) begin
        at15 = i;
        bus15.a_req = 1'b0;
      end
    end
    chk("w1_oe_cycles", 32'(oe1), 32'd1);
    chk("w15_oe_cycles", 32'(oe15), 32'd15);
    chk("w1_ack_cycle", 32'(at1), 32'd3);
    chk("w15_ack_cycle", 32'(at15), 32'd17);
    chk("w1_rdata", 32'(bus1.a_rdata), 32'h0000_1111);
    chk("w15_rdata", 32'(bus15.a_rdata), 32'h0000_2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: strobe width in clk cycles, legal range 1..15.
REQ-002 SHALL have these ports, one per line, as name direction width meaning, clock and reset first:
- clk  input  1  100 MHz board clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- a_req / b_req  input  1  access request, level, held high until the matching ack.
- a_we / b_we  input  1  1 = write, 0 = read; sampled at grant.
- a_addr / b_addr  input  19  word address; sampled at grant.
- a_wdata / b_wdata  input  16  write data; sampled at grant.
- a_rdata / b_rdata  output  16  read data, registered; valid from ack until the next read completes on that port.
- a_ack / b_ack  output  1  single-cycle completion pulse.
- sram_addr  output  19  SRAM address (top level drives ADR).
- sram_dq_o  output  16  SRAM write data.
- sram_dq_i  input  16  SRAM read data; the tristate buffer is at the top level.
- sram_dq_oe  output  1  data bus drive enable.
- sram_cs_n / sram_oe_n / sram_we_n  output  1  active-low SRAM strobes (drive RAMCS/RAMOE/RAMWE).
- busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-003 SHALL implement the FSM states IDLE, SETUP, STROBE and RECOVER, with all outputs registered.
REQ-004 IDLE: if any req is high, SHALL select a winner per REQ-010, latch its addr/we/wdata and go to SETUP; otherwise it SHALL stay in IDLE with all strobes high.
REQ-005 SETUP (1 cycle) SHALL drive: cs_n=0, oe_n=1, we_n=1, sram_addr=latched address; for writes also dq_oe=1 and dq_o=wdata.
REQ-006 STROBE SHALL last exactly WAIT_CYCLES cycles with we_n=0 (write) or oe_n=0 (read), counted by a 4-bit down-counter.
REQ-007 On the last STROBE cycle of a read, the block SHALL capture sram_dq_i into the winner's rdata register.
REQ-008 RECOVER (1 cycle) SHALL:
- drive oe_n=1 and we_n=1;
- hold cs_n=0, addr and dq_o/dq_oe;
- pulse the winner's ack;
- then return to IDLE with cs_n=1 and dq_oe=0.
REQ-009 Latency SHALL be req sampled in IDLE at cycle N -> ack high at cycle N+2+WAIT_CYCLES; the next access can start at N+3+WAIT_CYCLES.
REQ-010 Arbitration SHALL be fixed priority, A over B, unless SRAM_ARB_RR_EN is defined (see REQ-015).
REQ-011 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-012 Changes to a_*/b_* inputs after grant SHALL have no effect on the access in progress.
REQ-013 we_n and oe_n SHALL never be low in the same cycle, and neither SHALL be low while cs_n=1.

Reset
REQ-014 When rst_n=0 at a clock edge, on that edge the block SHALL:
- set the state to IDLE;
- set cs_n, oe_n, we_n to 1;
- clear dq_oe, sram_addr, dq_o, both acks, both rdata registers and busy to 0;
- set the round-robin pointer to "B last".
Reset mid-access SHALL abort the access with no ack.

Configuration
REQ-015 With macro SRAM_ARB_RR_EN defined, when both reqs are high in IDLE the grant SHALL go to the port not granted last; the pointer SHALL update on every grant. Without the macro, A SHALL always win and B SHALL be served only when a_req=0 in IDLE; the pointer SHALL be omitted.

Structure
REQ-016 Package edsac_sram_pkg SHALL hold SRAM_ADDR_W=19, SRAM_DATA_W=16 and the FSM state typedef.
REQ-017 The grant logic SHALL be a sub-module, sram_arb_grant (two requests, last-grant pointer, one-hot grant), instantiated by sram_arbiter.

Verification
REQ-018 A write then a read, addr 0x12345, data 0xBEEF, WAIT_CYCLES=2, with an SRAM model: a_ack in cycle N+4 each time, and a_rdata=0xBEEF.
REQ-019 a_req and b_req raised in the same cycle, macro off: A is served first, B is served directly after; with the macro on, a second simultaneous pair of requests is served B first.
REQ-020 a_req held continuously, b_req=1, macro off: B is never acked (starvation documented); with the macro on, acks alternate A,B,A,B.
REQ-021 rst_n=0 in the second STROBE cycle of a write: on the next edge we_n=1, cs_n=1, dq_oe=0, and no ack ever occurs.
REQ-022 WAIT_CYCLES=1 and WAIT_CYCLES=15: oe_n low for exactly 1 and 15 cycles respectively.
REQ-023 A protocol checker runs throughout all scenarios and flags any cycle where oe_n=0 with dq_oe=1, or any violation of REQ-013.
